// File: rtl/osb_pkg.sv
// Shared types and default widths for the Osborne VRAM arbiter slice.
package osb_pkg;
   localparam int OSB_AW = 16;
   localparam int OSB_DW = 8;

   typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
   typedef enum logic [1:0] {CPU_IDLE, CPU_PEND, CPU_BUSY} cpu_state_t;
endpackage

// File: rtl/osb_req_fifo.sv
// Pending video fetch addresses; head is visible combinationally while not empty.
// A push into a full FIFO is only accepted together with a pop in the same cycle.
module osb_req_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
   localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/osb_vram_arbiter.sv
// Shares the single-port VRAM between video fetch (priority) and the Z80 bus; grant to strobe is 3 cycles.
// The CPU is held off by video at most MAX_WAIT cycles; video slots it takes are absorbed by a small FIFO.
module osb_vram_arbiter
   import osb_pkg::*;
#(
   parameter int AW          = OSB_AW,
   parameter int DW          = OSB_DW,
   parameter int VFIFO_DEPTH = 2,
   parameter int MAX_WAIT    = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_valid,
   output logic [DW-1:0] vid_data,
   output logic          vid_overrun,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   cpu_state_t    state, state_nxt;
   logic [3:0]    cpu_wait, cpu_wait_nxt;
   logic          cpu_elig;
   logic          grant_cpu;
   logic          grant_vid_new;
   logic          fifo_pop;
   logic          fifo_push;
   logic          overrun_set;
   logic [AW-1:0] fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   owner_t        own_s1;
   owner_t        own_s2;

   osb_req_fifo #(
      .W     (AW),
      .DEPTH (VFIFO_DEPTH)
   ) u_vfifo (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (fifo_push),
      .din   (vid_addr),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A request seen in IDLE competes immediately so an uncontended access costs no extra cycle.
   always_comb begin
      cpu_elig      = (state == CPU_PEND) || ((state == CPU_IDLE) && cpu_req);
      grant_cpu     = 1'b0;
      grant_vid_new = 1'b0;
      fifo_pop      = 1'b0;
      if (cpu_elig && (cpu_wait >= WAIT_MAX)) begin
         grant_cpu = 1'b1;
      end else if (!fifo_empty) begin
         fifo_pop = 1'b1;
      end else if (vid_req) begin
         grant_vid_new = 1'b1;
      end else if (cpu_elig) begin
         grant_cpu = 1'b1;
      end
      fifo_push   = vid_req && !grant_vid_new && (!fifo_full || fifo_pop);
      overrun_set = vid_req && !grant_vid_new && fifo_full && !fifo_pop;
   end

   always_comb begin
      state_nxt    = state;
      cpu_wait_nxt = cpu_wait;
      case (state)
         CPU_IDLE, CPU_PEND: begin
            if (grant_cpu) begin
               state_nxt    = CPU_BUSY;
               cpu_wait_nxt = '0;
            end else if (cpu_elig) begin
               state_nxt    = CPU_PEND;
               cpu_wait_nxt = (cpu_wait >= WAIT_MAX) ? cpu_wait : cpu_wait + 4'd1;
            end
         end
         CPU_BUSY: begin
            cpu_wait_nxt = '0;
            if (cpu_ack) state_nxt = CPU_IDLE;
         end
         default: begin
            state_nxt    = CPU_IDLE;
            cpu_wait_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= CPU_IDLE;
         cpu_wait <= '0;
      end else begin
         state    <= state_nxt;
         cpu_wait <= cpu_wait_nxt;
      end
   end

   // Stage 1: drive the RAM; ram_addr holds its last value on idle cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
         own_s1    <= OWN_NONE;
      end else begin
         ram_we <= 1'b0;
         own_s1 <= OWN_NONE;
         if (grant_cpu) begin
            ram_addr <= cpu_addr;
            ram_we   <= cpu_we;
            own_s1   <= OWN_CPU;
            if (cpu_we) ram_wdata <= cpu_wdata;
         end else if (fifo_pop) begin
            ram_addr <= fifo_dout;
            own_s1   <= OWN_VID;
         end else if (grant_vid_new) begin
            ram_addr <= vid_addr;
            own_s1   <= OWN_VID;
         end
      end
   end

   // Stages 2/3: wait for the synchronous read, then strobe the owner.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         own_s2      <= OWN_NONE;
         vid_valid   <= 1'b0;
         vid_data    <= '0;
         cpu_ack     <= 1'b0;
         cpu_rdata   <= '0;
         vid_overrun <= 1'b0;
      end else begin
         own_s2    <= own_s1;
         vid_valid <= (own_s2 == OWN_VID);
         cpu_ack   <= (own_s2 == OWN_CPU);
         if (own_s2 == OWN_VID) vid_data  <= ram_rdata;
         if (own_s2 == OWN_CPU) cpu_rdata <= ram_rdata;
         if (overrun_set) vid_overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_osb_vram_arbiter.sv
// Directed bench for osb_vram_arbiter: per-cycle vector table plus starvation/overrun and reset sequences.
module tb_osb_vram_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        vid_req = 1'b0;
   logic [15:0] vid_addr = '0;
   logic        vid_valid;
   logic [7:0]  vid_data;
   logic        vid_overrun;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   osb_vram_arbiter #(
      .AW(16), .DW(8), .VFIFO_DEPTH(2), .MAX_WAIT(4)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
      .vid_data(vid_data), .vid_overrun(vid_overrun),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // RAM model: unwritten locations return a fixed address pattern.
   logic [7:0] mem [0:65535];
   bit         written [0:65535];

   function automatic logic [7:0] pat(input logic [15:0] a);
      if (a == 16'hF000) return 8'h41;
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   always @(posedge clk) begin
      ram_rdata <= written[ram_addr] ? mem[ram_addr] : pat(ram_addr);
      if (ram_we) begin
         mem[ram_addr]     <= ram_wdata;
         written[ram_addr] <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        vr;
      logic [15:0] va;
      logic        cr;
      logic        cw;
      logic [15:0] ca;
      logic [7:0]  cd;
      logic        e_vv;
      logic [7:0]  e_vd;
      logic        e_ack;
      logic        chk_rd;
      logic [7:0]  e_rd;
      logic        e_we;
      logic        chk_ra;
      logic [15:0] e_ra;
   } vec_t;

   vec_t tbl [19];
   logic [7:0] exp_q [$];
   int rx;

   initial begin
      //            vr  va       cr  cw  ca       cd     vv  vd     ack rdc rd     we  cra ra
      tbl[0]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'h0000};
      tbl[1]  = '{1'b1,16'hF000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,16'h0000};
      tbl[2]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'hF000};
      tbl[3]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'hF000};
      tbl[4]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h41,1'b0,1'b0,8'h00,1'b0,1'b0,16'h0000};
      tbl[5]  = '{1'b0,16'h0000,1'b1,1'b1,16'h1234,8'h5A,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,16'h0000};
      tbl[6]  = '{1'b0,16'h0000,1'b1,1'b1,16'h1234,8'h5A,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1,1'b1,16'h1234};
      tbl[7]  = '{1'b0,16'h0000,1'b1,1'b1,16'h1234,8'h5A,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'h1234};
      tbl[8]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,16'h0000};
      tbl[9]  = '{1'b0,16'h0000,1'b1,1'b0,16'h1234,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,16'h0000};
      tbl[10] = '{1'b0,16'h0000,1'b1,1'b0,16'h1234,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'h1234};
      tbl[11] = '{1'b0,16'h0000,1'b1,1'b0,16'h1234,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,16'h0000};
      tbl[12] = '{1'b0,16'h0000,1'b1,1'b0,16'h1234,8'h00,1'b0,8'h00,1'b1,1'b1,8'h5A,1'b0,1'b0,16'h0000};
      tbl[13] = '{1'b1,16'hF010,1'b1,1'b0,16'h0100,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'h1234};
      tbl[14] = '{1'b0,16'h0000,1'b1,1'b0,16'h0100,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'hF010};
      tbl[15] = '{1'b0,16'h0000,1'b1,1'b0,16'h0100,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'h0100};
      tbl[16] = '{1'b0,16'h0000,1'b1,1'b0,16'h0100,8'h00,1'b1,8'h45,1'b0,1'b0,8'h00,1'b0,1'b0,16'h0000};
      tbl[17] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,1'b1,1'b1,8'hA4,1'b0,1'b0,16'h0000};
      tbl[18] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,16'h0100};

      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vid_valid", vid_valid, 1'b0);
      chk("rst_cpu_ack", cpu_ack, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_addr", ram_addr, 16'h0);
      reset_n = 1'b1;

      // Single video read, CPU write/read, collision.
      for (int i = 0; i < 19; i++) begin
         step();
         chk($sformatf("tbl%0d_vid_valid", i), vid_valid, tbl[i].e_vv);
         chk($sformatf("tbl%0d_cpu_ack", i), cpu_ack, tbl[i].e_ack);
         chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].e_we);
         chk($sformatf("tbl%0d_overrun", i), vid_overrun, 1'b0);
         if (tbl[i].e_vv)   chk($sformatf("tbl%0d_vid_data", i), vid_data, tbl[i].e_vd);
         if (tbl[i].chk_rd) chk($sformatf("tbl%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_rd);
         if (tbl[i].chk_ra) chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].e_ra);
         if (tbl[i].e_we)   chk($sformatf("tbl%0d_ram_wdata", i), ram_wdata, 8'h5A);
         vid_req   = tbl[i].vr;
         vid_addr  = tbl[i].va;
         cpu_req   = tbl[i].cr;
         cpu_we    = tbl[i].cw;
         cpu_addr  = tbl[i].ca;
         cpu_wdata = tbl[i].cd;
      end

      // Video every cycle for 25 cycles with the CPU re-requesting: forced CPU
      // grants at 4, 12, 20 fill the FIFO, so the request at 20 is dropped.
      rx = 0;
      for (int c = 0; c < 45; c++) begin
         step();
         if (vid_valid) begin
            rx++;
            if (exp_q.size() == 0) chk("seq_vid_unexpected", 1'b1, 1'b0);
            else chk($sformatf("seq_vid_data_%0d", rx), vid_data, exp_q.pop_front());
         end
         chk($sformatf("seq_cpu_ack_c%0d", c), cpu_ack, (c == 7 || c == 15 || c == 23 || c == 30));
         if (cpu_ack) chk($sformatf("seq_cpu_rdata_c%0d", c), cpu_rdata, 8'h95);
         chk($sformatf("seq_ram_we_c%0d", c), ram_we, 1'b0);
         if (c == 4) begin
            chk("starve_ram_addr_c4", ram_addr, 16'h2003);
            chk("starve_cpu_wait_c4", dut.cpu_wait, 4'd4);
         end
         if (c == 5) begin
            chk("starve_ram_addr_c5", ram_addr, 16'h3000);
            chk("starve_cpu_wait_c5", dut.cpu_wait, 4'd0);
         end
         if (c <= 20) chk($sformatf("overrun_clear_c%0d", c), vid_overrun, 1'b0);
         if (c == 21 || c == 44) chk($sformatf("overrun_set_c%0d", c), vid_overrun, 1'b1);
         vid_req  = (c < 25);
         vid_addr = 16'h2000 + 16'(c);
         if (c < 25 && c != 20) exp_q.push_back(pat(vid_addr));
         cpu_req  = (c < 30);
         cpu_we   = 1'b0;
         cpu_addr = 16'h3000;
      end
      vid_req = 1'b0;
      chk("seq_vid_count", rx, 24);
      chk("seq_vid_leftover", exp_q.size(), 0);

      // Reset one cycle after a CPU write grant abandons it.
      step();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'h77;
      step();
      chk("rmid_ram_we_before", ram_we, 1'b1);
      chk("rmid_ram_addr_before", ram_addr, 16'h4000);
      reset_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0;
      #1;
      chk("rmid_ram_we", ram_we, 1'b0);
      chk("rmid_ram_addr", ram_addr, 16'h0);
      chk("rmid_ram_wdata", ram_wdata, 8'h0);
      chk("rmid_overrun", vid_overrun, 1'b0);
      chk("rmid_cpu_ack", cpu_ack, 1'b0);
      chk("rmid_vid_valid", vid_valid, 1'b0);
      chk("rmid_vid_data", vid_data, 8'h0);
      chk("rmid_cpu_rdata", cpu_rdata, 8'h0);
      step();
      step();
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("rpost_no_ack_%0d", c), cpu_ack, 1'b0);
         chk($sformatf("rpost_no_valid_%0d", c), vid_valid, 1'b0);
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
      step();
      chk("rnew_ram_addr", ram_addr, 16'h1234);
      chk("rnew_ack_n1", cpu_ack, 1'b0);
      step();
      chk("rnew_ack_n2", cpu_ack, 1'b0);
      step();
      chk("rnew_ack_n3", cpu_ack, 1'b1);
      chk("rnew_rdata", cpu_rdata, 8'h5A);
      cpu_req = 1'b0;
      step();
      chk("rnew_ack_n4", cpu_ack, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/osb_vram_arbiter.md
Name: osb_vram_arbiter

Overview:
- Shares the Osborne core's single-port 64 KiB main/video RAM between two requesters: the Z80 CPU bus wrapper and the character/attribute fetch unit of the video generator.
- Video has priority, with a bounded-starvation guarantee for the CPU and a small video request FIFO that absorbs slots the CPU takes.
- Sits inside mycore, between the CPU bus wrapper, the video fetch unit and the RAM macro.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- VFIFO_DEPTH, 2, pending video request slots (power of two, 1..4).
- MAX_WAIT, 4, CPU wait cycles after which the CPU wins the next slot (1..15).

Ports:
- clk  in  1  system clock (clk_sys)
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  video fetch request pulse, one per address, may be back-to-back
- vid_addr  in  AW  video fetch address, valid with vid_req
- vid_valid  out  1  one-cycle strobe, vid_data valid
- vid_data  out  DW  fetched byte, returned in request order
- vid_overrun  out  1  sticky, a video request was dropped
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, held with cpu_req
- cpu_addr  in  AW  CPU address, held with cpu_req
- cpu_wdata  in  DW  CPU write data, held with cpu_req
- cpu_ack  out  1  one-cycle completion strobe
- cpu_rdata  out  DW  read data, valid with cpu_ack
- ram_addr  out  AW  RAM address, registered
- ram_we  out  1  RAM write enable, registered
- ram_wdata  out  DW  RAM write data, registered
- ram_rdata  in  DW  RAM read data, 1-cycle synchronous read latency

Behaviour:
- Reset, asynchronous:
  - outputs: vid_valid, cpu_ack, ram_we, vid_overrun = 0; ram_addr, ram_wdata, vid_data, cpu_rdata = 0.
  - internal: FIFO empty, cpu_wait = 0, CPU state IDLE.
  - Reset mid-transaction abandons it; no ack or valid is issued afterwards.
- Pipeline, one RAM access per cycle:
  - Grant decided in cycle n.
  - ram_* driven in cycle n+1.
  - ram_rdata arrives in cycle n+2.
  - vid_valid/vid_data or cpu_ack/cpu_rdata are registered high in cycle n+3.
  - An uncontended request sampled in cycle n completes in cycle n+3, reads and writes alike.
  - A per-stage owner tag (NONE/VID/CPU) travels with each access.
- Video intake:
  - Each cycle, a vid_req is either granted directly (FIFO empty and video wins) or pushed into the FIFO.
  - If the FIFO is full and the request cannot be granted, the request is dropped and vid_overrun is set. vid_overrun clears only on reset.
  - The FIFO head is always granted before a new vid_req in the same cycle. The new request is then pushed (push and pop in the same cycle are allowed when full).
- CPU FSM states:
  - IDLE: on cpu_req go to PEND.
  - PEND: on grant go to BUSY.
  - BUSY: go to IDLE in the cycle cpu_ack is asserted.
  - cpu_req is ignored outside IDLE. A cpu_req still high in the cycle after cpu_ack is a new request.
- Grant priority per cycle:
  1. CPU, if PEND and cpu_wait >= MAX_WAIT.
  2. Video, FIFO head first, then new vid_req.
  3. CPU, if PEND.
  4. Otherwise idle: ram_we = 0, ram_addr holds its last value.
- cpu_wait: increments while PEND and not granted, saturates at MAX_WAIT, clears on CPU grant or when leaving PEND.
- A CPU grant forced by MAX_WAIT while a vid_req arrives pushes that vid_req into the FIFO. Worst-case video latency is 3 + VFIFO_DEPTH cycles.
- ram_we is high only for the single cycle of a CPU write access. Video never writes.

Decomposition:
- Package osb_pkg:
  - owner_t enum {OWN_NONE, OWN_VID, OWN_CPU}.
  - cpu_state_t enum {CPU_IDLE, CPU_PEND, CPU_BUSY}.
  - Default constants OSB_AW = 16, OSB_DW = 8.
- Sub-module osb_req_fifo: small synchronous FIFO (AW-wide, VFIFO_DEPTH) with push, pop, full and empty, async active-low reset.

Test Plan:
- Single video read: vid_req at cycle 10, addr 0x F000, RAM holds 0x41 → ram_addr = 0xF000 in cycle 11, vid_valid = 1 with vid_data = 0x41 in cycle 13 only.
- CPU write then read: write 0x5A to 0x1234 → ram_we = 1 for exactly one cycle, cpu_ack 3 cycles after the request. Then a read of 0x1234 → cpu_rdata = 0x5A with cpu_ack.
- Collision: vid_req (0x F010) and cpu_req (read 0x0100) in the same cycle → video is accessed first, the CPU in the next cycle, cpu_ack one cycle after vid_valid.
- Starvation with MAX_WAIT = 4: continuous vid_req every cycle plus a CPU read → CPU granted on its 5th pending cycle, cpu_wait returns to 0, and all video data returns in order with none dropped.
- Overrun with VFIFO_DEPTH = 2: stall video with forced CPU grants while the FIFO is full and a vid_req arrives → that request gets no vid_valid and vid_overrun stays 1 until reset.
- Reset mid-operation: assert reset_n = 0 in the cycle after a CPU grant → no cpu_ack, all outputs 0. After release, a fresh request completes with normal latency.
